// File: rtl/fre_auto_ctrl.sv
// Measurement sequencer around the equal-precision frequency meter: periodic start pulses,
// sample capture on end_flag edges, power-of-two averaging and binary-to-BCD conversion.
module fre_auto_ctrl #(
    parameter int START_PERIOD = 25_000_000,
    parameter int TIMEOUT      = 1_000_000,
    parameter int AVG_LOG2     = 2
) (
    input  logic        std_clk,
    input  logic        std_reset,
    input  logic        enable,
    input  logic        meas_end_flag,
    input  logic [9:0]  meas_fre_val,
    output logic        start_flag,
    output logic [9:0]  result_bin,
    output logic [15:0] result_bcd,
    output logic        result_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam int ACC_W = 10 + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam int PER_W = $clog2(START_PERIOD);
    localparam int TMO_W = $clog2(TIMEOUT);

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(START_PERIOD - 1);
    // START itself takes one cycle of the period, so WAIT leaves one count early.
    localparam logic [PER_W-1:0] PER_GO   = PER_W'(START_PERIOD - 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_MEASURE,
        S_WAIT,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_end_d;
    logic [ACC_W-1:0]   r_acc;
    logic [SMP_W-1:0]   r_smp_cnt;
    logic [PER_W-1:0]   r_period_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [3:0]         r_conv_cnt;
    logic [9:0]         r_avg;
    logic [25:0]        r_dd;
    logic               r_start_flag;
    logic [9:0]         r_result_bin;
    logic [15:0]        r_result_bcd;
    logic               r_result_valid;
    logic               r_busy;
    logic               r_timeout_err;

    logic               w_end_rise;
    logic [9:0]         w_avg;
    logic [15:0]        w_bcd_adj;
    logic [25:0]        w_dd_adj;

    assign w_end_rise = meas_end_flag & ~r_end_d;
    assign w_avg      = r_acc[AVG_LOG2 +: 10];

    // Double-dabble: every BCD digit >= 5 gets +3 before the register shifts left.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dabble
        assign w_bcd_adj[gi*4 +: 4] = (r_dd[10 + gi*4 +: 4] >= 4'd5) ?
                                      r_dd[10 + gi*4 +: 4] + 4'd3 :
                                      r_dd[10 + gi*4 +: 4];
    end
    assign w_dd_adj = {w_bcd_adj, r_dd[9:0]};

    always_ff @(posedge std_clk or negedge std_reset) begin
        if (!std_reset) begin
            r_state        <= S_IDLE;
            r_end_d        <= 1'b0;
            r_acc          <= '0;
            r_smp_cnt      <= '0;
            r_period_cnt   <= '0;
            r_tmo_cnt      <= '0;
            r_conv_cnt     <= '0;
            r_avg          <= '0;
            r_dd           <= '0;
            r_start_flag   <= 1'b0;
            r_result_bin   <= '0;
            r_result_bcd   <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_end_d        <= meas_end_flag;
            r_start_flag   <= 1'b0;
            r_result_valid <= 1'b0;
            if (!enable) begin
                r_state       <= S_IDLE;
                r_busy        <= 1'b0;
                r_acc         <= '0;
                r_smp_cnt     <= '0;
                r_period_cnt  <= '0;
                r_tmo_cnt     <= '0;
                r_conv_cnt    <= '0;
                r_timeout_err <= 1'b0;
            end else begin
                r_busy <= 1'b1;
                if (r_state != S_IDLE && r_state != S_START && r_period_cnt != PER_LAST)
                    r_period_cnt <= r_period_cnt + PER_W'(1);
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_START;
                    end
                    S_START: begin
                        r_start_flag <= 1'b1;
                        r_period_cnt <= '0;
                        r_tmo_cnt    <= '0;
                        r_state      <= S_MEASURE;
                    end
                    S_MEASURE: begin
                        if (w_end_rise) begin
                            r_acc      <= r_acc + ACC_W'(meas_fre_val);
                            r_smp_cnt  <= r_smp_cnt + SMP_W'(1);
                            r_conv_cnt <= '0;
                            r_state    <= (r_smp_cnt == SMP_LAST) ? S_CONVERT : S_WAIT;
                        end else if (r_tmo_cnt == TMO_LAST) begin
                            r_timeout_err <= 1'b1;
                            r_acc         <= '0;
                            r_smp_cnt     <= '0;
                            r_state       <= S_WAIT;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                        end
                    end
                    S_WAIT: begin
                        if (r_period_cnt >= PER_GO)
                            r_state <= S_START;
                    end
                    S_CONVERT: begin
                        if (r_conv_cnt == 4'd0) begin
                            r_avg      <= w_avg;
                            r_dd       <= {16'h0000, w_avg};
                            r_conv_cnt <= 4'd1;
                        end else begin
                            r_dd       <= w_dd_adj << 1;
                            r_conv_cnt <= r_conv_cnt + 4'd1;
                            if (r_conv_cnt == 4'd10)
                                r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_result_bin   <= r_avg;
                        r_result_bcd   <= r_dd[25:10];
                        r_result_valid <= 1'b1;
                        r_acc          <= '0;
                        r_smp_cnt      <= '0;
                        r_state        <= S_WAIT;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign start_flag   = r_start_flag;
    assign result_bin   = r_result_bin;
    assign result_bcd   = r_result_bcd;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_fre_auto_ctrl.sv
// Bench for fre_auto_ctrl: a meter model answers start pulses from a response plan and
// a scoreboard checks each averaged result, its latency and the start-pulse spacing.
module tb_fre_auto_ctrl;

    localparam int SP  = 2000;
    localparam int TMO = 1000;
    localparam int AL  = 2;

    logic        std_clk       = 1'b0;
    logic        std_reset     = 1'b0;
    logic        enable        = 1'b0;
    logic        meas_end_flag = 1'b0;
    logic [9:0]  meas_fre_val  = 10'd0;
    logic        start_flag;
    logic [9:0]  result_bin;
    logic [15:0] result_bcd;
    logic        result_valid;
    logic        busy;
    logic        timeout_err;

    fre_auto_ctrl #(
        .START_PERIOD(SP),
        .TIMEOUT     (TMO),
        .AVG_LOG2    (AL)
    ) dut (
        .std_clk      (std_clk),
        .std_reset    (std_reset),
        .enable       (enable),
        .meas_end_flag(meas_end_flag),
        .meas_fre_val (meas_fre_val),
        .start_flag   (start_flag),
        .result_bin   (result_bin),
        .result_bcd   (result_bcd),
        .result_valid (result_valid),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 std_clk = ~std_clk;

    typedef struct {
        int          delay;
        logic [9:0]  val;
        int          hold;
        bit          spur;
        bit          drop;
        bit          last;
        logic [9:0]  exp_bin;
        logic [15:0] exp_bcd;
    } resp_t;

    typedef struct {
        int              delay;
        int              hold;
        bit              spur;
        int              pre;
        logic [3:0][9:0] v;
        logic [9:0]      exp_bin;
        logic [15:0]     exp_bcd;
        bit              exp_tmo;
    } vec_t;

    typedef struct {
        logic [9:0]  bin;
        logic [15:0] bcd;
        int          due;
    } exp_t;

    resp_t plan_q[$];
    exp_t  sb_q[$];
    vec_t  tbl[7];

    int cyc        = 0;
    int total      = 0;
    int bad        = 0;
    int n_results  = 0;
    int n_starts   = 0;
    int last_start = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic set_vec(input int i, input int delay, input int hold, input bit spur,
                           input int pre, input logic [9:0] a, input logic [9:0] b,
                           input logic [9:0] c, input logic [9:0] d,
                           input logic [9:0] eb, input logic [15:0] ebcd, input bit et);
        tbl[i].delay   = delay;
        tbl[i].hold    = hold;
        tbl[i].spur    = spur;
        tbl[i].pre     = pre;
        tbl[i].v[0]    = a;
        tbl[i].v[1]    = b;
        tbl[i].v[2]    = c;
        tbl[i].v[3]    = d;
        tbl[i].exp_bin = eb;
        tbl[i].exp_bcd = ebcd;
        tbl[i].exp_tmo = et;
    endtask

    task automatic push_vec(input int i);
        resp_t r;
        for (int k = 0; k < tbl[i].pre; k++) begin
            r = '{600, 10'd1000, 1, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0};
            plan_q.push_back(r);
        end
        if (tbl[i].pre > 0) begin
            r = '{0, 10'd0, 1, 1'b0, 1'b1, 1'b0, 10'd0, 16'd0};
            plan_q.push_back(r);
        end
        for (int k = 0; k < 4; k++) begin
            r = '{tbl[i].delay, tbl[i].v[k], tbl[i].hold, tbl[i].spur, 1'b0, (k == 3),
                  tbl[i].exp_bin, tbl[i].exp_bcd};
            plan_q.push_back(r);
        end
    endtask

    task automatic wait_results(input int n, input int budget);
        int k;
        k = 0;
        while (n_results < n && k < budget) begin
            @(negedge std_clk);
            k++;
        end
        check($sformatf("result_%0d_arrived", n), 32'(n_results >= n), 32'd1);
    endtask

    task automatic wait_start(input int budget);
        int ns;
        int k;
        ns = n_starts;
        k  = 0;
        while (n_starts == ns && k < budget) begin
            @(negedge std_clk);
            k++;
        end
        check("start_seen", 32'(n_starts != ns), 32'd1);
    endtask

    initial forever begin
        @(posedge std_clk);
        cyc++;
    end

    // Start-pulse monitor: spacing between consecutive pulses of one enabled run.
    initial forever begin
        @(negedge std_clk);
        if (start_flag) begin
            if (last_start >= 0)
                check("start_period", 32'(cyc - last_start), 32'(SP));
            last_start = cyc;
            n_starts++;
        end
    end

    // Result monitor: pops the scoreboard on every result_valid pulse.
    initial begin : result_mon
        exp_t e;
        forever begin
            @(negedge std_clk);
            if (result_valid) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got result_valid=1 bin=%0d, want no pending result, cycle %0d",
                             result_bin, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_bin", 32'(result_bin), 32'(e.bin));
                    check("sb_bcd", 32'(result_bcd), 32'(e.bcd));
                    check("sb_latency", 32'(cyc), 32'(e.due));
                    $display("result %0d: bin=%0d bcd=%04h cycle=%0d", n_results, result_bin, result_bcd, cyc);
                end
                n_results++;
            end
        end
    end

    // Meter model: each start pulse consumes one planned response.
    initial begin : meter
        resp_t r;
        exp_t  e;
        forever begin
            @(negedge std_clk);
            if (start_flag && plan_q.size() != 0) begin
                r = plan_q.pop_front();
                if (r.drop) begin
                    repeat (TMO - 1) @(negedge std_clk);
                    check("tmo_before_limit", 32'(timeout_err), 32'd0);
                    @(negedge std_clk);
                    check("tmo_at_limit", 32'(timeout_err), 32'd1);
                end else begin
                    repeat (r.delay) @(negedge std_clk);
                    meas_fre_val  = r.val;
                    meas_end_flag = 1'b1;
                    if (r.last) begin
                        e = '{r.exp_bin, r.exp_bcd, cyc + 13};
                        sb_q.push_back(e);
                    end
                    repeat (r.hold) @(negedge std_clk);
                    meas_end_flag = 1'b0;
                    meas_fre_val  = 10'd0;
                    if (r.spur) begin
                        repeat (50) @(negedge std_clk);
                        meas_fre_val  = 10'd1023;
                        meas_end_flag = 1'b1;
                        @(negedge std_clk);
                        meas_end_flag = 1'b0;
                        meas_fre_val  = 10'd0;
                    end
                end
            end
        end
    end

    initial begin : main
        resp_t r;
        //      i  delay hold spur pre  samples                      bin     bcd       tmo
        set_vec(0, 600,  1,   0,   0,   100,  101,  102,  103,       10'd101,  16'h0101, 1'b0);
        set_vec(1, 600,  1,   0,   0,   1023, 1023, 1023, 1023,      10'd1023, 16'h1023, 1'b0);
        set_vec(2, 600,  1,   0,   0,   0,    0,    0,    0,         10'd0,    16'h0000, 1'b0);
        set_vec(3, 600,  5,   1,   0,   40,   50,   60,   70,        10'd55,   16'h0055, 1'b0);
        set_vec(4, 999,  1,   0,   0,   999,  1000, 998,  1001,      10'd999,  16'h0999, 1'b0);
        set_vec(5, 600,  1,   0,   1,   4,    4,    4,    4,         10'd4,    16'h0004, 1'b1);
        set_vec(6, 600,  1,   0,   0,   500,  501,  502,  503,       10'd501,  16'h0501, 1'b0);

        std_reset = 1'b0;
        enable    = 1'b1;
        repeat (5) @(negedge std_clk);
        check("rst_start_flag", 32'(start_flag), 32'd0);
        check("rst_result_bin", 32'(result_bin), 32'd0);
        check("rst_result_bcd", 32'(result_bcd), 32'h0000);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_no_starts", 32'(n_starts), 32'd0);

        enable    = 1'b0;
        std_reset = 1'b1;
        repeat (3) @(negedge std_clk);
        check("idle_busy", 32'(busy), 32'd0);

        push_vec(0);
        enable = 1'b1;
        @(negedge std_clk);
        check("en_edge1_start", 32'(start_flag), 32'd0);
        check("en_edge1_busy", 32'(busy), 32'd1);
        @(negedge std_clk);
        check("en_edge2_start", 32'(start_flag), 32'd1);

        for (int i = 0; i < 6; i++) begin
            wait_results(i + 1, 20000);
            check($sformatf("vec%0d_bin", i), 32'(result_bin), 32'(tbl[i].exp_bin));
            check($sformatf("vec%0d_bcd", i), 32'(result_bcd), 32'(tbl[i].exp_bcd));
            check($sformatf("vec%0d_tmo", i), 32'(timeout_err), 32'(tbl[i].exp_tmo));
            if (i < 5)
                push_vec(i + 1);
        end

        // Disable part-way through a measurement.
        r = '{600, 10'd77, 1, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0};
        plan_q.push_back(r);
        wait_start(3000);
        repeat (300) @(negedge std_clk);
        enable     = 1'b0;
        last_start = -1;
        @(negedge std_clk);
        check("dis_busy", 32'(busy), 32'd0);
        check("dis_tmo_cleared", 32'(timeout_err), 32'd0);
        check("dis_bin_kept", 32'(result_bin), 32'(tbl[5].exp_bin));
        check("dis_bcd_kept", 32'(result_bcd), 32'(tbl[5].exp_bcd));
        begin
            int ns;
            ns = n_starts;
            repeat (2500) @(negedge std_clk);
            check("dis_no_start", 32'(n_starts - ns), 32'd0);
        end
        check("dis_bin_still", 32'(result_bin), 32'(tbl[5].exp_bin));

        // Re-enable and run one more full average.
        push_vec(6);
        enable = 1'b1;
        @(negedge std_clk);
        check("reen_edge1_start", 32'(start_flag), 32'd0);
        check("reen_edge1_busy", 32'(busy), 32'd1);
        @(negedge std_clk);
        check("reen_edge2_start", 32'(start_flag), 32'd1);
        wait_results(7, 10000);
        check("vec6_bin", 32'(result_bin), 32'(tbl[6].exp_bin));
        check("vec6_bcd", 32'(result_bcd), 32'(tbl[6].exp_bcd));
        check("vec6_tmo", 32'(timeout_err), 32'(tbl[6].exp_tmo));

        // Asynchronous reset in the middle of a measurement.
        r = '{600, 10'd88, 1, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0};
        plan_q.push_back(r);
        wait_start(3000);
        repeat (100) @(negedge std_clk);
        @(posedge std_clk);
        #2;
        std_reset = 1'b0;
        #1;
        check("arst_start_flag", 32'(start_flag), 32'd0);
        check("arst_result_bin", 32'(result_bin), 32'd0);
        check("arst_result_bcd", 32'(result_bcd), 32'h0000);
        check("arst_result_valid", 32'(result_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_timeout_err", 32'(timeout_err), 32'd0);
        repeat (3) @(negedge std_clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
